// File: rtl/seq_multiplier_nbits.sv
// seq_multiplier_nbits: sequential radix-4 Booth multiplier, one Booth step per cycle over WIDTH/2+1 cycles.
// Define SEQMULT_SIGNED_EN to let sgn select two's-complement operands; without it every operation is unsigned.
module seq_multiplier_nbits #(
   parameter int WIDTH = 8
) (
   input  logic               CLK,
   input  logic               RESET_N,
   input  logic               start,
   input  logic               sgn,
   input  logic [WIDTH-1:0]   x,
   input  logic [WIDTH-1:0]   y,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] result
);
   localparam int PW = 2 * WIDTH;
   localparam int XW = WIDTH + 3;
   localparam int MW = WIDTH + 3;
   localparam int CW = $clog2(WIDTH / 2 + 1);
   typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
   state_t        state_q, state_d;
   logic [XW-1:0] x_q, x_d;
   logic [MW-1:0] m_q, m_d;
   logic [PW-1:0] acc_q, acc_d;
   logic [PW-1:0] result_q, result_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [XW-1:0] pp;
   logic [PW-1:0] pp_sh;
   logic          mode;
`ifdef SEQMULT_SIGNED_EN
   assign mode = sgn;
`else
   logic unused_sgn;
   assign unused_sgn = sgn;
   assign mode = 1'b0;
`endif
   // m_q holds the extended multiplier with an implicit zero below bit 0; its low three bits form the Booth triplet.
   always_comb begin
      pp = (m_q[2:0] == 3'b001 || m_q[2:0] == 3'b010) ? x_q :
           (m_q[2:0] == 3'b011) ? {x_q[XW-2:0], 1'b0} :
           (m_q[2:0] == 3'b100) ? -{x_q[XW-2:0], 1'b0} :
           (m_q[2:0] == 3'b101 || m_q[2:0] == 3'b110) ? -x_q : '0;
      pp_sh = {{(PW-XW){pp[XW-1]}}, pp} << {cnt_q, 1'b0};
   end
   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      m_d      = m_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      case (state_q)
         ITER: begin
            acc_d = acc_q + pp_sh;
            m_d   = m_q >> 2;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH / 2)) begin
               state_d  = DONE;
               result_d = acc_q + pp_sh;
            end
         end
         default: begin
            state_d = start ? ITER : IDLE;
            if (start) begin
               x_d   = mode ? {{3{x[WIDTH-1]}}, x} : {3'b000, x};
               m_d   = {mode ? {2{y[WIDTH-1]}} : 2'b00, y, 1'b0};
               acc_d = '0;
               cnt_d = '0;
            end
         end
      endcase
   end
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q  <= IDLE;
         x_q      <= '0;
         m_q      <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         m_q      <= m_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end
   assign busy   = (state_q == ITER);
   assign done   = (state_q == DONE);
   assign result = result_q;
endmodule

// File: tb/tb_seq_multiplier_nbits.sv
// tb_seq_multiplier_nbits: directed checks on an 8-bit instance plus back-to-back random products on a 16-bit instance.
module tb_seq_multiplier_nbits;
`ifdef SEQMULT_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        s8 = 1'b0, sg8 = 1'b0;
   logic [7:0]  x8 = '0, y8 = '0;
   logic        busy8, done8;
   logic [15:0] res8;
   logic        s16 = 1'b0, sg16 = 1'b0;
   logic [15:0] x16 = '0, y16 = '0;
   logic        busy16, done16;
   logic [31:0] res16;
   int n_chk = 0;
   int n_pass = 0;
   always #5 clk = ~clk;
   seq_multiplier_nbits #(.WIDTH(8)) dut8 (
      .CLK(clk), .RESET_N(rst_n), .start(s8), .sgn(sg8), .x(x8), .y(y8),
      .busy(busy8), .done(done8), .result(res8)
   );
   seq_multiplier_nbits #(.WIDTH(16)) dut16 (
      .CLK(clk), .RESET_N(rst_n), .start(s16), .sgn(sg16), .x(x16), .y(y16),
      .busy(busy16), .done(done16), .result(res16)
   );
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   // Latency counts rising edges with the accepting edge as number 1.
   task automatic run8(input string tag, input logic sg, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] es, input logic [15:0] eu);
      int n;
      @(negedge clk);
      s8 = 1'b1; sg8 = sg; x8 = a; y8 = b;
      @(negedge clk);
      s8 = 1'b0;
      n = 1;
      chk({tag, "_busy"}, 64'(busy8), 64'd1);
      while (!done8 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_lat"}, 64'(n), 64'd6);
      chk({tag, "_res"}, 64'(res8), 64'((sg && SIGNED_EN) ? es : eu));
      chk({tag, "_busy_done"}, 64'(busy8), 64'd0);
   endtask
   task automatic new_op16(output logic [31:0] e);
      logic [15:0] a, b;
      logic        sg;
      logic signed [31:0] ps;
      a  = 16'($urandom);
      b  = 16'($urandom);
      sg = 1'($urandom_range(0, 1));
      x16 = a; y16 = b; sg16 = sg;
      if (sg && SIGNED_EN) begin
         ps = $signed(a) * $signed(b);
         e  = ps;
      end else begin
         e = a * b;
      end
   endtask
   logic [15:0] es_v [8] = '{16'hFFF1, 16'hFE01, 16'h0001, 16'h4000, 16'hC080, 16'h0000, 16'h3F01, 16'hFFFF};
   logic [15:0] eu_v [8] = '{16'h02F1, 16'hFE01, 16'hFE01, 16'h4000, 16'h3F80, 16'h0000, 16'h3F01, 16'h00FF};
   logic [7:0]  xa_v [8] = '{8'h03, 8'hFF, 8'hFF, 8'h80, 8'h80, 8'h00, 8'h7F, 8'hFF};
   logic [7:0]  yb_v [8] = '{8'hFB, 8'hFF, 8'hFF, 8'h80, 8'h7F, 8'hAB, 8'h7F, 8'h01};
   logic        sg_v [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
   initial begin
      int n, dn;
      logic [15:0] last;
      logic [31:0] e16;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_busy", 64'(busy8), 64'd0);
      chk("rst_done", 64'(done8), 64'd0);
      chk("rst_res", 64'(res8), 64'd0);
      chk("rst_res16", 64'(res16), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++)
         run8($sformatf("vec%0d", i), sg_v[i], xa_v[i], yb_v[i], es_v[i], eu_v[i]);
      // A second start arriving mid-operation must be dropped.
      @(negedge clk);
      s8 = 1'b1; sg8 = 1'b1; x8 = 8'h03; y8 = 8'hFB;
      @(negedge clk);
      s8 = 1'b0;
      @(negedge clk);
      s8 = 1'b1; x8 = 8'h07; y8 = 8'h07;
      @(negedge clk);
      s8 = 1'b0;
      dn = 0;
      last = '0;
      repeat (12) begin
         @(negedge clk);
         if (done8) begin
            dn++;
            last = res8;
         end
      end
      chk("ign_done_cnt", 64'(dn), 64'd1);
      chk("ign_res", 64'(last), 64'(SIGNED_EN ? 16'hFFF1 : 16'h02F1));
      // Reset during ITER aborts the operation.
      @(negedge clk);
      s8 = 1'b1; sg8 = 1'b0; x8 = 8'h09; y8 = 8'h09;
      @(negedge clk);
      s8 = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", 64'(busy8), 64'd0);
      chk("abort_done", 64'(done8), 64'd0);
      chk("abort_res", 64'(res8), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dn = 0;
      repeat (10) begin
         @(negedge clk);
         if (done8) dn++;
      end
      chk("abort_no_done", 64'(dn), 64'd0);
      run8("post_rst", 1'b0, 8'h05, 8'h06, 16'h001E, 16'h001E);
      // Back-to-back 16-bit products with start held high.
      @(negedge clk);
      s16 = 1'b1;
      new_op16(e16);
      for (int i = 0; i < 200; i++) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!done16 && n < 40);
         chk($sformatf("b2b%0d_lat", i), 64'(n), 64'd10);
         chk($sformatf("b2b%0d_res", i), 64'(res16), 64'(e16));
         if (i < 199) new_op16(e16);
         else s16 = 1'b0;
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
